// File: rtl/ps2_frame_ctrl.sv
// ps2_frame_ctrl: PS/2 receive controller with frame checking, E0/F0 prefix
// folding into key events, watchdog abort and a small FWFT event FIFO.
// Ports: clk, rst (sync, active-high); ps2c/ps2d async pins;
// ev_valid/ev_ready/ev_code/ev_break/ev_ext event handshake;
// frame_err (1-cycle pulse), overflow (sticky), busy (FSM not idle).
module ps2_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DECODE
  } state_e;

  logic c_s1_q, c_s2_q, c_prev_q;
  logic d_s1_q, d_s2_q;
  logic fe, din;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              push;
  logic              in_frame;

  logic [9:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full, pop, wr_en;
  logic [9:0]        head;

  // Sync stages idle high so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1_q   <= 1'b1;
      c_s2_q   <= 1'b1;
      c_prev_q <= 1'b1;
      d_s1_q   <= 1'b1;
      d_s2_q   <= 1'b1;
    end else begin
      c_s1_q   <= ps2c;
      c_s2_q   <= c_s1_q;
      c_prev_q <= c_s2_q;
      d_s1_q   <= ps2d;
      d_s2_q   <= d_s1_q;
    end
  end

  assign fe  = c_prev_q & ~c_s2_q;
  assign din = d_s2_q;

  assign in_frame = (state_q == S_DATA) ||
                    (state_q == S_PARITY) ||
                    (state_q == S_STOP);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    wdog_d    = '0;
    ext_d     = ext_q;
    brk_d     = brk_q;
    err_d     = 1'b0;
    push      = 1'b0;

    if (in_frame) begin
      wdog_d = fe ? '0 : wdog_q + WD_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (fe) begin
          if (!din) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fe) begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fe) begin
          par_d   = din;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fe) begin
          if (din && (^{shift_q, par_q})) begin
            state_d = S_DECODE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (shift_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          push  = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An edge in the same cycle keeps the frame alive.
    if (in_frame && !fe && wdog_q == WD_W'(TIMEOUT_CYC)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      wdog_d  = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // FIFO: a pop in the same cycle frees the slot for a push when full.
  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    pop      = ev_valid & ev_ready;
    wr_en    = push & (~full | pop);
    wr_ptr_d = wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
    ovf_d    = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      wdog_q    <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      wdog_q    <= wdog_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ext_q, brk_q, shift_q};
  end

  // Storage is not reset, so the head is masked while empty.
  assign head      = mem_q[rd_ptr_q];
  assign ev_valid  = (cnt_q != '0);
  assign ev_code   = ev_valid ? head[7:0] : 8'h00;
  assign ev_break  = ev_valid & head[8];
  assign ev_ext    = ev_valid & head[9];
  assign frame_err = err_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// tb_ps2_frame_ctrl: randomized self-checking bench for ps2_frame_ctrl
// against a byte-level prefix-folding reference model.
module tb_ps2_frame_ctrl;

  localparam int TO  = 200;
  localparam int H   = 4;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int err_pulses = 0;
  int err_run = 0;
  int err_max = 0;
  int valid_cyc = 0;
  bit m_ext = 1'b0;
  bit m_brk = 1'b0;

  ps2_frame_ctrl #(.TIMEOUT_CYC(TO), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_break(ev_break), .ev_ext(ev_ext),
    .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready)
      got_q.push_back({ev_ext, ev_break, ev_code});
    if (!rst && ev_valid) valid_cyc++;
    if (frame_err) begin
      if (err_run == 0) err_pulses++;
      err_run++;
      if (err_run > err_max) err_max = err_run;
    end else begin
      err_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    tick(H);
    ps2c = 1'b0;
    tick(H);
    ps2c = 1'b1;
  endtask

  task automatic send_upto_stop(input logic [7:0] b,
                                input bit bp, input bit bs);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bp);
    ps2d = ~bs;
    tick(H);
    ps2c = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit bp, input bit bs);
    send_upto_stop(b, bp, bs);
    tick(H);
    ps2c = 1'b1;
    ps2d = 1'b1;
    tick(GAP);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    model_byte(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    m_ext = 1'b0;
    m_brk = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total++;
    if ({ev_valid, ev_code, ev_break, ev_ext} !== 11'd0) begin
      bad++;
      $display("FAIL reset_ev got=%b want=0",
               {ev_valid, ev_code, ev_break, ev_ext});
    end
    total++;
    if ({frame_err, overflow, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {frame_err, overflow, busy});
    end
    do_reset();
  endtask

  task automatic test_single_make();
    int e0, v0;
    ev_ready = 1'b1;
    got_q.delete();
    e0 = err_pulses;
    v0 = valid_cyc;
    send_upto_stop(8'h1C, 1'b0, 1'b0);
    tick(3);
    total++;
    if (ev_valid !== 1'b0) begin
      bad++;
      $display("FAIL make_early got=%b want=0", ev_valid);
    end
    tick(1);
    total++;
    if ({ev_valid, ev_code} !== {1'b1, 8'h1C}) begin
      bad++;
      $display("FAIL make_latency got=%b/%h want=1/1c",
               ev_valid, ev_code);
    end
    ps2c = 1'b1;
    ps2d = 1'b1;
    tick(GAP);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 10'h01C) begin
      bad++;
      $display("FAIL make_event got_n=%0d want=1 (code 1c)",
               got_q.size());
    end
    total++;
    if (valid_cyc - v0 != 1) begin
      bad++;
      $display("FAIL make_valid_cyc got=%0d want=1", valid_cyc - v0);
    end
    total++;
    if (err_pulses != e0) begin
      bad++;
      $display("FAIL make_err got=%0d want=%0d", err_pulses, e0);
    end
  endtask

  task automatic test_prefixes();
    got_q.delete();
    exp_q.delete();
    send_good(8'hF0);
    send_good(8'h1C);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h74);
    total++;
    if (got_q.size() != exp_q.size() || exp_q.size() != 2) begin
      bad++;
      $display("FAIL prefix_count got=%0d want=2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL prefix_ev%0d got=%h want=%h",
                   i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_parity_err();
    int e0;
    got_q.delete();
    exp_q.delete();
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b0);
    send_good(8'h32);
    total++;
    if (err_pulses != e0 + 1) begin
      bad++;
      $display("FAIL parity_err got=%0d want=%0d", err_pulses, e0 + 1);
    end
    total++;
    if (got_q.size() != 1 || got_q[0] !== 10'h032) begin
      bad++;
      $display("FAIL parity_next got_n=%0d want=1 (code 32)",
               got_q.size());
    end
  endtask

  task automatic test_timeout();
    int e0;
    got_q.delete();
    exp_q.delete();
    send_good(8'hE0);
    send_good(8'hF0);
    e0 = err_pulses;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    tick(TO + 10);
    m_ext = 1'b0;
    m_brk = 1'b0;
    total++;
    if (err_pulses != e0 + 1) begin
      bad++;
      $display("FAIL timeout_err got=%0d want=%0d", err_pulses, e0 + 1);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_busy got=%b want=0", busy);
    end
    ps2d = 1'b1;
    send_good(8'h15);
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL timeout_next got_n=%0d want=1 (code 015)",
               got_q.size());
    end
  endtask

  task automatic test_random();
    int e0, exp_err, r;
    logic [7:0] b;
    got_q.delete();
    exp_q.delete();
    e0 = err_pulses;
    exp_err = 0;
    ev_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 11);
      b = 8'($urandom_range(0, 255));
      if (r < 2) send_good(8'hE0);
      else if (r < 4) send_good(8'hF0);
      else if (r == 4) begin
        send_frame(b, 1'b1, 1'b0);
        exp_err++;
      end else if (r == 5) begin
        send_frame(b, 1'b0, 1'b1);
        exp_err++;
      end else if (r == 6) begin
        send_bit(1'b1);
        tick(GAP);
        exp_err++;
      end else send_good(b);
    end
    total++;
    if (err_pulses - e0 != exp_err) begin
      bad++;
      $display("FAIL rand_err got=%0d want=%0d",
               err_pulses - e0, exp_err);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count got=%0d want=%0d",
               got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rand_ev%0d got=%h want=%h",
                   i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] seq [5];
    seq = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_good(seq[i]);
    total++;
    if ({overflow, ev_valid, ev_code} !== {2'b11, 8'h16}) begin
      bad++;
      $display("FAIL ovf_state got=%b%b/%h want=11/16",
               overflow, ev_valid, ev_code);
    end
    got_q.delete();
    ev_ready = 1'b1;
    tick(8);
    total++;
    if (got_q.size() != 4) begin
      bad++;
      $display("FAIL ovf_drain_n got=%0d want=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_q[i] !== {2'b00, seq[i]}) begin
          bad++;
          $display("FAIL ovf_ev%0d got=%h want=%h",
                   i, got_q[i], seq[i]);
        end
      end
    end
    total++;
    if (ev_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_empty got=%b want=0", ev_valid);
    end
  endtask

  task automatic test_collision();
    logic [7:0] seq [5];
    seq = '{8'h1C, 8'h32, 8'h15, 8'h16, 8'h45};
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_good(seq[i]);
    got_q.delete();
    send_upto_stop(8'h45, 1'b0, 1'b0);
    tick(3);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    ps2c = 1'b1;
    ps2d = 1'b1;
    tick(GAP);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL coll_ovf got=%b want=0", overflow);
    end
    ev_ready = 1'b1;
    tick(8);
    ev_ready = 1'b0;
    total++;
    if (got_q.size() != 5) begin
      bad++;
      $display("FAIL coll_n got=%0d want=5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got_q[i] !== {2'b00, seq[i]}) begin
          bad++;
          $display("FAIL coll_ev%0d got=%h want=%h",
                   i, got_q[i], seq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    ev_ready = 1'b0;
    send_good(8'h1C);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2c = 1'b0;
    tick(3);
    total++;
    if ({busy, ev_valid} !== 2'b11) begin
      bad++;
      $display("FAIL rmid_pre got=%b want=11", {busy, ev_valid});
    end
    e0 = err_pulses;
    rst = 1'b1;
    tick(1);
    total++;
    if ({ev_valid, ev_code, ev_break, ev_ext,
         frame_err, overflow, busy} !== 14'd0) begin
      bad++;
      $display("FAIL rmid_out got=%b want=0",
               {ev_valid, ev_code, ev_break, ev_ext,
                frame_err, overflow, busy});
    end
    ps2c = 1'b1;
    ps2d = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(TO + 20);
    total++;
    if (err_pulses != e0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_err got=%0d/%b want=%0d/0",
               err_pulses, busy, e0);
    end
  endtask

  task automatic test_err_width();
    total++;
    if (err_max != 1) begin
      bad++;
      $display("FAIL err_width got=%0d want=1", err_max);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_prefixes();
    test_parity_err();
    test_timeout();
    test_random();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_err_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
